// File: rtl/seq_gen_arbiter.sv
// ---------------------------------------------------------------------------
// seq_gen_arbiter
//   Round-robin arbiter in front of a single 3-flop sequence generator.
//   Two clients each request a burst of N generator steps. The winner gets
//   the generator cleared to 000, then receives N consecutive step results
//   (state + carry), followed by a one-cycle done pulse.
//
// Ports
//   clk      in   1      rising-edge clock
//   reset    in   1      synchronous active-high reset
//   req0     in   1      client 0 burst request (held until gnt0)
//   len0     in   LEN_W  client 0 burst length, sampled at grant decision
//   req1     in   1      client 1 burst request (held until gnt1)
//   len1     in   LEN_W  client 1 burst length, sampled at grant decision
//   gnt0     out  1      client 0 owns the generator
//   gnt1     out  1      client 1 owns the generator
//   owner    out  1      id of the current owner, 0 when nothing is granted
//   q        out  3      generator state {Q1,Q2,Q3}
//   c        out  1      generator carry
//   q_valid  out  1      q/c carry a fresh step result this cycle
//   done     out  1      one-cycle pulse at the end of a burst
// ---------------------------------------------------------------------------
module seq_gen_arbiter #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [LEN_W-1:0] len0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             owner,
  output logic [2:0]       q,
  output logic             c,
  output logic             q_valid,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic [2:0]       q_q, q_d;
  logic             c_q, c_d;
  logic             q_valid_q, q_valid_d;
  logic             done_q, done_d;
  logic             winner;

  // Arbitration: a lone requester wins; on a tie the client that did not
  // own the generator last time wins. ptr_q holds the last owner, and
  // resets to 1 so that client 0 wins the first tie.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~ptr_q;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

  // State register together with every registered output. All outputs come
  // straight from flops so clients see glitch-free signals.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= 1'b1;
      owner_q   <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      q_q       <= 3'b000;
      c_q       <= 1'b0;
      q_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      q_q       <= q_d;
      c_q       <= c_d;
      q_valid_q <= q_valid_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic. cnt holds the number of step results still to be
  // produced; every transition into RUN produces one result, so the burst
  // leaves RUN once cnt has reached zero. A zero-length burst goes straight
  // from GRANT to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = GRANT;
          owner_d = winner;
          cnt_d   = winner ? len1 : len0;
        end
      end
      GRANT, RUN: begin
        if (cnt_q != '0) begin
          state_d = RUN;
          cnt_d   = cnt_q - CNT_ONE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = owner_q;
        owner_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic, computed from the upcoming state so the flops present
  // values matching the state being entered. The generator is cleared on
  // entry to GRANT and steps once for every cycle spent in RUN; otherwise
  // q/c hold their last value.
  always_comb begin
    gnt0_d    = (state_d != IDLE) && !owner_d;
    gnt1_d    = (state_d != IDLE) && owner_d;
    q_valid_d = (state_d == RUN);
    done_d    = (state_d == DONE);
    q_d       = q_q;
    c_d       = c_q;
    if ((state_q == IDLE) && (state_d == GRANT)) begin
      q_d = 3'b000;
      c_d = 1'b0;
    end else if (state_d == RUN) begin
      q_d = {~q_q[0], q_q[2], q_q[2] & q_q[1]};
      c_d = ~q_q[0] | q_q[2];
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign owner   = owner_q;
  assign q       = q_q;
  assign c       = c_q;
  assign q_valid = q_valid_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_gen_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seq_gen_arbiter
//   Scoreboard bench for seq_gen_arbiter. The driver issues one input set
//   per cycle; whenever the reference model is idle it decides the next
//   burst and queues the expected output of every cycle of that burst.
//   A separate monitor pops one expectation per clock and compares.
// ---------------------------------------------------------------------------
module tb_seq_gen_arbiter;

  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1;
  logic [LEN_W-1:0] len0, len1;
  logic             gnt0, gnt1, owner;
  logic [2:0]       q;
  logic             c, q_valid, done;

  // Expected output word: {gnt0, gnt1, owner, q[2:0], c, q_valid, done}
  logic [8:0] expQ[$];

  int  checks   = 0;
  int  failures = 0;
  int  cycleNum = 0;
  bit  monEnable = 1'b0;

  // Reference model state
  logic       lastOwner;
  logic [2:0] lastQ;
  logic       lastC;

  // Generator results from a cleared state repeat with period 5
  logic [2:0] seqTab [5] = '{3'b100, 3'b110, 3'b111, 3'b011, 3'b000};
  logic       carTab [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  seq_gen_arbiter #(.LEN_W(LEN_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .len0    (len0),
    .req1    (req1),
    .len1    (len1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .owner   (owner),
    .q       (q),
    .c       (c),
    .q_valid (q_valid),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] mkExp(input logic g0, input logic g1,
                                       input logic own, input logic [2:0] qq,
                                       input logic cc, input logic qv,
                                       input logic dn);
    return {g0, g1, own, qq, cc, qv, dn};
  endfunction

  // Drive one cycle of inputs and advance the reference model. When the
  // model has nothing queued the DUT is idle at the coming edge, so this is
  // the decision point: queue a whole burst (GRANT, L results, DONE, one
  // idle cycle) or a single idle cycle.
  task automatic applyStimulus(input logic rst, input logic r0,
                               input logic [LEN_W-1:0] l0, input logic r1,
                               input logic [LEN_W-1:0] l1);
    logic             w;
    int               n;
    @(negedge clk);
    reset = rst;
    req0  = r0;
    len0  = l0;
    req1  = r1;
    len1  = l1;
    if (rst) begin
      expQ.delete();
      expQ.push_back(9'b0);
      lastOwner = 1'b1;
      lastQ     = 3'b000;
      lastC     = 1'b0;
    end else if (expQ.size() == 0) begin
      if (r0 || r1) begin
        if (r0 && r1) w = (lastOwner == 1'b1) ? 1'b0 : 1'b1;
        else          w = r1;
        n = w ? int'(l1) : int'(l0);
        expQ.push_back(mkExp(~w, w, w, 3'b000, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < n; i++) begin
          expQ.push_back(mkExp(~w, w, w, seqTab[i % 5], carTab[i % 5], 1'b1, 1'b0));
        end
        if (n > 0) begin
          lastQ = seqTab[(n - 1) % 5];
          lastC = carTab[(n - 1) % 5];
        end else begin
          lastQ = 3'b000;
          lastC = 1'b0;
        end
        expQ.push_back(mkExp(~w, w, w, lastQ, lastC, 1'b0, 1'b1));
        expQ.push_back(mkExp(1'b0, 1'b0, 1'b0, lastQ, lastC, 1'b0, 1'b0));
        lastOwner = w;
      end else begin
        expQ.push_back(mkExp(1'b0, 1'b0, 1'b0, lastQ, lastC, 1'b0, 1'b0));
      end
    end
    monEnable = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  // Compare the DUT outputs of this cycle against the next expectation.
  task automatic checkOutput();
    logic [8:0] act;
    logic [8:0] exp;
    act = {gnt0, gnt1, owner, q, c, q_valid, done};
    checks++;
    if (expQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty cycle=%0d actual=%09b required=queued expectation",
               cycleNum, act);
    end else begin
      exp = expQ.pop_front();
      if (act !== exp) begin
        failures++;
        $display("[TB] FAIL outputs cycle=%0d actual=%09b required=%09b (g0 g1 own q2 q1 q0 c qv done)",
                 cycleNum, act, exp);
      end
    end
    checks++;
    if (gnt0 && gnt1) begin
      failures++;
      $display("[TB] FAIL gnt_exclusive cycle=%0d actual gnt0=%0b gnt1=%0b required not both",
               cycleNum, gnt0, gnt1);
    end
  endtask

  // Monitor: samples just after each rising edge, independent of the driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cycleNum++;
      if (monEnable) checkOutput();
    end
  end

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; len0 = '0; len1 = '0;
    lastOwner = 1'b1; lastQ = 3'b000; lastC = 1'b0;

    // Reset state
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);

    // Single requester 0, burst of 3
    applyStimulus(1'b0, 1'b1, 4'd3, 1'b0, '0);
    idleCycles(7);

    // Requester 1, burst of 6 (wraps the period-5 loop)
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 4'd6);
    idleCycles(10);

    // Both held with length 1: alternating grants
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 4'd1, 1'b1, 4'd1);
    idleCycles(5);

    // Zero-length burst
    applyStimulus(1'b0, 1'b1, 4'd0, 1'b0, '0);
    idleCycles(4);

    // Reset in the middle of a length-6 burst, then a tie goes to client 0
    applyStimulus(1'b0, 1'b1, 4'd6, 1'b0, '0);
    idleCycles(3);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 4'd2, 1'b1, 4'd5);
    idleCycles(6);

    // Owner drops req and changes len mid-burst; burst still completes
    applyStimulus(1'b0, 1'b1, 4'd4, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 4'd4, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 4'd9, 1'b0, '0);
    idleCycles(7);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(99, 0) == 0),
                    ($urandom_range(2, 0) != 0), LEN_W'($urandom_range(15, 0)),
                    ($urandom_range(2, 0) != 0), LEN_W'($urandom_range(15, 0)));
    end

    // Let any burst in flight finish, then check the last queued cycle
    idleCycles(25);
    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
